// File: rtl/cplx_trivial_rot.sv
// cplx_trivial_rot: two-stage valid/ready pipeline applying trivial complex rotations
// (pass, negate, conjugate, *j, *-j) with a wrapping output handshake counter.
// Optional macro CPLX_ROT_SAT_EN: saturate negation of the most negative value and raise sat_flag.
module cplx_trivial_rot #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   input  logic [2:0]   mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   input  logic         clr,
   output logic         sat_flag,
   output logic [15:0]  sample_cnt
);
   logic         s1_valid;
   logic [W-1:0] s1_re;
   logic [W-1:0] s1_im;
   logic [2:0]   s1_mode;
   logic [W-1:0] neg_re;
   logic [W-1:0] neg_im;
   logic [W-1:0] res_re;
   logic [W-1:0] res_im;
   logic         s2_load;
   logic         s1_load;

   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

`ifdef CPLX_ROT_SAT_EN
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
   logic sat_evt;

   // Negation clamps the most negative value to the most positive one instead of wrapping
   always_comb begin
      neg_re  = s1_re == MIN ? ~MIN : -s1_re;
      neg_im  = s1_im == MIN ? ~MIN : -s1_im;
      sat_evt = s1_valid && (((s1_mode == 3'd1 || s1_mode == 3'd4) && s1_re == MIN) ||
                             ((s1_mode == 3'd1 || s1_mode == 3'd2 || s1_mode == 3'd3) && s1_im == MIN));
   end

   // Sticky saturation flag, set when a clamped result loads into S2; clr wins
   always_ff @(posedge clk or posedge rst)
      if (rst)
         sat_flag <= 1'b0;
      else if (clr)
         sat_flag <= 1'b0;
      else if (s2_load && sat_evt)
         sat_flag <= 1'b1;
`else
   assign neg_re   = -s1_re;
   assign neg_im   = -s1_im;
   assign sat_flag = 1'b0;
`endif

   // Mode decode on the S1 operands; modes 5..7 fall through to pass
   always_comb begin
      res_re = s1_mode == 3'd1 ? neg_re :
               s1_mode == 3'd3 ? neg_im :
               s1_mode == 3'd4 ? s1_im  : s1_re;
      res_im = (s1_mode == 3'd1 || s1_mode == 3'd2) ? neg_im :
               s1_mode == 3'd3 ? s1_re  :
               s1_mode == 3'd4 ? neg_re : s1_im;
   end

   // S1: capture operands and mode together whenever the stage can move
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_valid <= 1'b0;
         s1_re    <= '0;
         s1_im    <= '0;
         s1_mode  <= '0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         s1_re    <= in_re;
         s1_im    <= in_im;
         s1_mode  <= mode;
      end

   // S2: registered result, held while downstream stalls
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         out_re    <= res_re;
         out_im    <= res_im;
      end

   // Output handshake counter, wrapping; clr wins over a coincident transfer
   always_ff @(posedge clk or posedge rst)
      if (rst)
         sample_cnt <= '0;
      else if (clr)
         sample_cnt <= '0;
      else if (out_valid && out_ready)
         sample_cnt <= sample_cnt + 16'd1;
endmodule

// File: tb/tb_cplx_trivial_rot.sv
// tb_cplx_trivial_rot: scoreboard bench for cplx_trivial_rot with a behavioural rotation model,
// directed scenarios and random backpressure. Honours CPLX_ROT_SAT_EN like the design.
module tb_cplx_trivial_rot;
`ifdef CPLX_ROT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   typedef struct {
      logic [31:0] re;
      logic [31:0] im;
      int          acc;
      bit          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_re;
   logic [31:0] in_im;
   logic [2:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_re;
   logic [31:0] out_im;
   logic        clr;
   logic        sat_flag;
   logic [15:0] sample_cnt;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   n_out = 0;
   bit   bp_mode = 1'b0;
   bit   lat_on = 1'b0;
   bit   exp_sat = 1'b0;

   cplx_trivial_rot #(.W(32)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_re(in_re),
      .in_im(in_im),
      .mode(mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_re(out_re),
      .out_im(out_im),
      .clr(clr),
      .sat_flag(sat_flag),
      .sample_cnt(sample_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] fit(input longint x);
      if (x > 64'sd2147483647) return SAT ? 32'h7fff_ffff : 32'h8000_0000;
      return x[31:0];
   endfunction

   // Reference: complex arithmetic on wide integers, then fit back into 32 bits
   function automatic void model(input logic [31:0] re, input logic [31:0] im, input logic [2:0] m,
                                 output logic [31:0] ore, output logic [31:0] oim, output bit evt);
      longint r;
      longint i;
      longint xr;
      longint xi;
      r = longint'($signed(re));
      i = longint'($signed(im));
      case (m)
         3'd1: begin xr = -r; xi = -i; end
         3'd2: begin xr = r;  xi = -i; end
         3'd3: begin xr = -i; xi = r;  end
         3'd4: begin xr = i;  xi = -r; end
         default: begin xr = r; xi = i; end
      endcase
      evt = (xr > 64'sd2147483647) || (xi > 64'sd2147483647);
      ore = fit(xr);
      oim = fit(xi);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = ($urandom % 3) != 0;
   endtask

   task automatic push(input logic [31:0] re, input logic [31:0] im, input logic [2:0] m);
      exp_t        e;
      logic [31:0] xr;
      logic [31:0] xi;
      bit          evt;
      model(re, im, m, xr, xi, evt);
      e.re  = xr;
      e.im  = xi;
      e.acc = cyc + 1;
      e.lat = lat_on;
      exp_sat = exp_sat | (evt & SAT);
      sbq.push_back(e);
   endtask

   // Present one sample (called just after a rising edge) and hold it until accepted
   task automatic send(input logic [31:0] re, input logic [31:0] im, input logic [2:0] m);
      in_valid = 1'b1;
      in_re = re;
      in_im = im;
      mode = m;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            push(re, im, m);
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
      end
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 500 && sbq.size() != 0; k++) tick();
      chk("drain_pending", 64'(sbq.size()), 64'(0));
      tick();
   endtask

   task automatic clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_out = 0;
      exp_sat = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks stall stability
   task automatic monitor();
      bit          held = 1'b0;
      logic [31:0] h_re = '0;
      logic [31:0] h_im = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) held = 1'b0;
         else begin
            if (held) begin
               chk("hold_valid", 64'(out_valid), 64'(1));
               chk("hold_data", {out_re, out_im}, {h_re, h_im});
            end
            if (out_valid && out_ready) begin
               if (sbq.size() == 0) chk("unexpected_output", 64'(out_valid), 64'(0));
               else begin
                  e = sbq.pop_front();
                  chk("out_data", {out_re, out_im}, {e.re, e.im});
                  if (e.lat) chk("latency", 64'(cyc + 1 - e.acc), 64'(2));
                  n_out++;
               end
            end
            held = out_valid && !out_ready;
            h_re = out_re;
            h_im = out_im;
         end
      end
   endtask

   initial begin
      logic [31:0] re;
      logic [31:0] im;
      int          acc;
      int          t0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_re = '0;
      in_im = '0;
      mode = '0;
      out_ready = 1'b1;
      clr = 1'b0;
      fork
         monitor();
      join_none
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", {out_re, out_im}, 64'(0));
      chk("rst_sat_flag", 64'(sat_flag), 64'(0));
      chk("rst_sample_cnt", 64'(sample_cnt), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(in_ready), 64'(1));

      // Mode sweep on (5,-3), each result two cycles after acceptance
      tick();
      lat_on = 1'b1;
      for (int m = 0; m < 8; m++) send(32'd5, -32'sd3, 3'(m));
      drain();
      @(negedge clk);
      chk("sweep_cnt", 64'(sample_cnt), 64'(8));

      // Back-to-back stream of 8 after a clear
      tick();
      clear();
      t0 = cyc;
      for (int k = 0; k < 8; k++) send($urandom, $urandom, 3'($urandom_range(0, 7)));
      chk("stream_back_to_back", 64'(cyc - t0), 64'(8));
      drain();
      @(negedge clk);
      chk("stream_cnt", 64'(sample_cnt), 64'(8));
      lat_on = 1'b0;

      // Backpressure: only two samples fit while out_ready is low
      tick();
      out_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_re = 32'(100 + acc);
         in_im = 32'(200 + acc);
         mode = 3'(acc);
         @(negedge clk);
         if (in_ready) begin
            push(in_re, in_im, mode);
            acc++;
         end
         tick();
      end
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_accepted", 64'(acc), 64'(2));
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 2; k < 6; k++) send(32'(100 + k), 32'(200 + k), 3'(k));
      drain();
      @(negedge clk);
      chk("bp_cnt", 64'(sample_cnt), 64'(14));

      // Overflow of the most negative value under negate, then clear
      tick();
      send(32'h8000_0000, 32'd0, 3'd1);
      drain();
      @(negedge clk);
      chk("ovf_sat_flag", 64'(sat_flag), 64'(exp_sat));
      tick();
      clear();
      @(negedge clk);
      chk("clr_sat_flag", 64'(sat_flag), 64'(0));
      chk("clr_sample_cnt", 64'(sample_cnt), 64'(0));

      // clr coinciding with a saturating S2 load
      tick();
      send(32'd3, 32'h8000_0000, 3'd2);
      clear();
      drain();
      @(negedge clk);
      chk("clr_vs_sat", 64'(sat_flag), 64'(exp_sat));
      chk("clr_vs_sat_cnt", 64'(sample_cnt), 64'(n_out));

      // clr coinciding with an output transfer
      tick();
      out_ready = 1'b0;
      send(32'd1, 32'd2, 3'd0);
      for (int k = 0; k < 10 && !out_valid; k++) tick();
      out_ready = 1'b1;
      clear();
      @(negedge clk);
      chk("clr_vs_xfer_cnt", 64'(sample_cnt), 64'(0));
      chk("clr_vs_xfer_sbq", 64'(sbq.size()), 64'(0));

      // Random samples, modes and backpressure, with frequent most-negative operands
      tick();
      bp_mode = 1'b1;
      for (int k = 0; k < 300; k++) begin
         re = $urandom;
         im = $urandom;
         if ($urandom_range(0, 7) == 0) re = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) im = 32'h8000_0000;
         send(re, im, 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) tick();
      end
      bp_mode = 1'b0;
      out_ready = 1'b1;
      drain();
      @(negedge clk);
      chk("rand_sat_flag", 64'(sat_flag), 64'(exp_sat));
      chk("rand_cnt", 64'(sample_cnt), 64'(16'(n_out)));

      // Asynchronous reset with both stages full discards everything
      tick();
      out_ready = 1'b0;
      send(32'd11, 32'd12, 3'd0);
      send(32'd13, 32'd14, 3'd1);
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'(0));
      chk("full_out_valid", 64'(out_valid), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'(0));
      chk("arst_out_data", {out_re, out_im}, 64'(0));
      chk("arst_cnt", 64'(sample_cnt), 64'(0));
      chk("arst_sat", 64'(sat_flag), 64'(0));
      sbq.delete();
      n_out = 0;
      exp_sat = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_post_arst", 64'(in_ready), 64'(1));
      tick();
      out_ready = 1'b1;
      lat_on = 1'b1;
      send(32'd7, 32'd1, 3'd3);
      drain();
      @(negedge clk);
      chk("post_arst_cnt", 64'(sample_cnt), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
